// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock's time-setting path.
// Holds the mode encodings driven on set_time_ctrl.mode and the default timing constants.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_e;

  localparam int unsigned DefHoldMs   = 500;
  localparam int unsigned DefRepeatMs = 200;
  localparam int unsigned DefTimeoutS = 10;
  localparam int unsigned DefBlinkMs  = 250;

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detect plus press-and-hold auto-repeat for one debounced key.
// Ports:
//   clk      system clock
//   cr       synchronous active-high clear
//   tick_ms  1 kHz one-clk strobe, time base for hold/repeat
//   key      debounced key level
//   arm      1 = pulses allowed; 0 clears the counters and locks out a key held across it
//   pulse    combinational request, one per rise and one per hold/repeat expiry
module key_repeat
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_MS   = DefHoldMs,
  parameter int unsigned REPEAT_MS = DefRepeatMs
) (
  input  logic clk,
  input  logic cr,
  input  logic tick_ms,
  input  logic key,
  input  logic arm,
  output logic pulse
);

  localparam int unsigned MaxMs = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int unsigned CntW  = $clog2(MaxMs) + 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_MS - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_MS - 1);

  logic            key_q;
  logic            lock_q, lock_d;
  logic            rep_q, rep_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise, live, fire;

  always_comb begin
    rise  = key & ~key_q;
    live  = arm & key & ~lock_q;
    fire  = 1'b0;
    cnt_d = cnt_q;
    rep_d = rep_q;
    if (!live) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (tick_ms) begin
      if (cnt_q == (rep_q ? RepLast : HoldLast)) begin
        fire  = 1'b1;
        cnt_d = '0;
        rep_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse  = live & (rise | fire);
    // A key still held when arm drops stays locked until it is released.
    lock_d = key & (lock_q | ~arm);
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      key_q  <= 1'b0;
      lock_q <= 1'b0;
      rep_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      key_q  <= key;
      lock_q <= lock_d;
      rep_q  <= rep_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/set_time_ctrl.sv
// Mode/sequencing controller for the clock's time-setting path.
// RUN -> SET_HOUR -> SET_MIN -> RUN on each mode-button press, with increment pulses,
// auto-repeat, idle timeout back to RUN and digit blink masks. All outputs registered.
// Ports:
//   clk, cr               clock and synchronous active-high clear
//   tick_ms, tick_1hz     1 kHz and 1 Hz one-clk strobes
//   btn_mode, btn_inc     debounced button levels
//   run_en                seconds-timebase enable, 1 only in RUN
//   en                    one-clk increment pulse to the datapath
//   min_hour              1 = minute counter, 0 = hour counter
//   blink_hi, blink_lo    blank hour / minute digits this cycle
//   mode                  current state encoding
module set_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_MS   = DefHoldMs,
  parameter int unsigned REPEAT_MS = DefRepeatMs,
  parameter int unsigned TIMEOUT_S = DefTimeoutS,
  parameter int unsigned BLINK_MS  = DefBlinkMs
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       tick_ms,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_en,
  output logic       en,
  output logic       min_hour,
  output logic       blink_hi,
  output logic       blink_lo,
  output logic [1:0] mode
);

  localparam int unsigned IdleW  = $clog2(TIMEOUT_S) + 1;
  localparam int unsigned BlinkW = $clog2(BLINK_MS) + 1;
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(TIMEOUT_S - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_MS - 1);

  mode_e             state_q, state_d;
  logic              btn_mode_q;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic              min_hour_d;
  logic              mode_rise, in_set, timeout, arm, inc_pulse, entering;

  key_repeat #(
    .HOLD_MS  (HOLD_MS),
    .REPEAT_MS(REPEAT_MS)
  ) u_key_repeat (
    .clk    (clk),
    .cr     (cr),
    .tick_ms(tick_ms),
    .key    (btn_inc),
    .arm    (arm),
    .pulse  (inc_pulse)
  );

  always_comb begin
    mode_rise = btn_mode & ~btn_mode_q;
    in_set    = (state_q == MODE_SET_HOUR) || (state_q == MODE_SET_MIN);
    timeout   = in_set & tick_1hz & (idle_q == IdleLast);
    // Mode change or timeout in this clk drops any increment request.
    arm       = in_set & ~mode_rise & ~timeout;

    state_d = state_q;
    case (state_q)
      MODE_RUN:      if (mode_rise) state_d = MODE_SET_HOUR;
      MODE_SET_HOUR: begin
        if (timeout)        state_d = MODE_RUN;
        else if (mode_rise) state_d = MODE_SET_MIN;
      end
      MODE_SET_MIN:  if (timeout || mode_rise) state_d = MODE_RUN;
      default:       state_d = MODE_RUN;
    endcase

    min_hour_d = min_hour;
    if (state_d == MODE_SET_HOUR) min_hour_d = 1'b0;
    if (state_d == MODE_SET_MIN)  min_hour_d = 1'b1;

    idle_d = idle_q;
    if (!in_set || mode_rise || inc_pulse || timeout) begin
      idle_d = '0;
    end else if (tick_1hz && idle_q != '1) begin
      idle_d = idle_q + 1'b1;
    end

    entering    = (state_d != state_q);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_d == MODE_RUN || entering) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (tick_ms) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      state_q     <= MODE_RUN;
      btn_mode_q  <= 1'b0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      run_en      <= 1'b1;
      en          <= 1'b0;
      min_hour    <= 1'b0;
      blink_hi    <= 1'b0;
      blink_lo    <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_mode_q  <= btn_mode;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      run_en      <= (state_d == MODE_RUN);
      en          <= inc_pulse;
      min_hour    <= min_hour_d;
      // Digits stay visible while the inc button is held.
      blink_hi    <= (state_d == MODE_SET_HOUR) & phase_d & ~btn_inc;
      blink_lo    <= (state_d == MODE_SET_MIN) & phase_d & ~btn_inc;
    end
  end

  assign mode = state_q;

endmodule

// File: tb/tb_set_time_ctrl.sv
module tb_set_time_ctrl;

  localparam int unsigned HoldMs   = 500;
  localparam int unsigned RepeatMs = 200;
  localparam int unsigned TimeoutS = 10;
  localparam int unsigned BlinkMs  = 250;

  logic       clk = 1'b0;
  logic       cr, tick_ms, tick_1hz, btn_mode, btn_inc;
  logic       run_en, en, min_hour, blink_hi, blink_lo;
  logic [1:0] mode;

  int tests = 0;
  int fails = 0;
  int ms_now;
  int en_seen;
  int en_at[$];

  set_time_ctrl #(
    .HOLD_MS  (HoldMs),
    .REPEAT_MS(RepeatMs),
    .TIMEOUT_S(TimeoutS),
    .BLINK_MS (BlinkMs)
  ) dut (
    .clk     (clk),
    .cr      (cr),
    .tick_ms (tick_ms),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .run_en  (run_en),
    .en      (en),
    .min_hour(min_hour),
    .blink_hi(blink_hi),
    .blink_lo(blink_lo),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // One clock; outputs sampled 1 time unit after the edge, en pulses logged.
  task automatic step();
    @(posedge clk);
    #1;
    if (en === 1'b1) begin
      en_seen++;
      en_at.push_back(ms_now);
    end
  endtask

  task automatic ms_tick();
    tick_ms = 1'b1;
    ms_now++;
    step();
    tick_ms = 1'b0;
  endtask

  task automatic sec_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic clear_log();
    ms_now  = 0;
    en_seen = 0;
    en_at.delete();
  endtask

  task automatic do_reset();
    cr = 1'b1; tick_ms = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    step();
    step();
    cr = 1'b0;
    clear_log();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
  endtask

  task automatic enter_state(input int presses);
    do_reset();
    for (int i = 0; i < presses; i++) press_mode();
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({mode, run_en, en, min_hour, blink_hi, blink_lo} !== {2'b00, 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL reset_state: got mode=%b run_en=%b en=%b mh=%b bh=%b bl=%b want 00 1 0 0 0 0",
               mode, run_en, en, min_hour, blink_hi, blink_lo);
    end
    for (int i = 0; i < 4; i++) begin
      btn_inc = 1'b1;
      repeat ($urandom_range(1, 5)) step();
      btn_inc = 1'b0;
      repeat ($urandom_range(1, 5)) step();
    end
    tests++;
    if (en_seen != 0) begin
      fails++;
      $display("FAIL run_inc_ignored: got %0d en pulses want 0", en_seen);
    end
  endtask

  task automatic test_modes();
    logic [1:0] exp_mode;
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      btn_mode = 1'b1;
      repeat ($urandom_range(1, 6)) step();
      btn_mode = 1'b0;
      repeat ($urandom_range(1, 4)) step();
      exp_mode = 2'(p % 3);
      tests++;
      if (mode !== exp_mode || run_en !== (p % 3 == 0) || min_hour !== (p >= 2)) begin
        fails++;
        $display("FAIL mode_press%0d: got mode=%b run_en=%b mh=%b want mode=%b run_en=%b mh=%b",
                 p, mode, run_en, min_hour, exp_mode, p % 3 == 0, p >= 2);
      end
    end
  endtask

  task automatic test_short_press();
    int n;
    enter_state(1);
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step();
      tests++;
      if (en !== 1'b1) begin
        fails++;
        $display("FAIL short_latency%0d: got en=%b want 1", i, en);
      end
      repeat ($urandom_range(1, 8)) step();
      btn_inc = 1'b0;
      repeat ($urandom_range(1, 4)) step();
    end
    tests++;
    if (en_seen != n) begin
      fails++;
      $display("FAIL short_count: got %0d pulses want %0d", en_seen, n);
    end
  endtask

  task automatic test_hold(input int hold_ms);
    int exp_at[$];
    enter_state(1);
    exp_at.push_back(0);
    for (int m = HoldMs; m <= hold_ms; m += RepeatMs) exp_at.push_back(m);
    btn_inc = 1'b1;
    step();
    for (int n = 0; n < hold_ms; n++) begin
      repeat ($urandom_range(0, 2)) step();
      ms_tick();
    end
    btn_inc = 1'b0;
    repeat (3) step();
    tests++;
    if (en_at.size() != exp_at.size()) begin
      fails++;
      $display("FAIL hold%0d_count: got %0d pulses want %0d", hold_ms, en_at.size(),
               exp_at.size());
    end
    for (int i = 0; i < exp_at.size() && i < en_at.size(); i++) begin
      tests++;
      if (en_at[i] != exp_at[i]) begin
        fails++;
        $display("FAIL hold%0d_pulse%0d: got ms %0d want ms %0d", hold_ms, i, en_at[i],
                 exp_at[i]);
      end
    end
  endtask

  task automatic test_timeout();
    // No buttons: back to RUN on exactly the TimeoutS-th second.
    enter_state(2);
    for (int s = 1; s <= TimeoutS; s++) begin
      repeat ($urandom_range(0, 3)) step();
      sec_tick();
      if (s >= TimeoutS - 1) begin
        tests++;
        if (mode !== ((s == TimeoutS) ? 2'b00 : 2'b10)) begin
          fails++;
          $display("FAIL timeout_idle_s%0d: got mode=%b want %b", s, mode,
                   (s == TimeoutS) ? 2'b00 : 2'b10);
        end
      end
    end
    // An inc press restarts the idle count.
    enter_state(2);
    repeat (TimeoutS - 1) sec_tick();
    btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
    step();
    for (int s = 1; s <= TimeoutS; s++) begin
      sec_tick();
      if (s >= TimeoutS - 1) begin
        tests++;
        if (mode !== ((s == TimeoutS) ? 2'b00 : 2'b10)) begin
          fails++;
          $display("FAIL timeout_restart_s%0d: got mode=%b want %b", s, mode,
                   (s == TimeoutS) ? 2'b00 : 2'b10);
        end
      end
    end
    // Timeout and mode press in the same clk from SET_HOUR: RUN, not SET_MIN.
    enter_state(1);
    repeat (TimeoutS - 1) sec_tick();
    btn_mode = 1'b1;
    sec_tick();
    btn_mode = 1'b0;
    step();
    tests++;
    if (mode !== 2'b00 || run_en !== 1'b1) begin
      fails++;
      $display("FAIL timeout_vs_mode: got mode=%b run_en=%b want 00 1", mode, run_en);
    end
  endtask

  task automatic test_simultaneous();
    enter_state(1);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    tests++;
    if (mode !== 2'b10 || min_hour !== 1'b1) begin
      fails++;
      $display("FAIL simul_mode: got mode=%b mh=%b want 10 1", mode, min_hour);
    end
    for (int n = 0; n < 1100; n++) ms_tick();
    tests++;
    if (en_seen != 0) begin
      fails++;
      $display("FAIL simul_no_repeat: got %0d pulses want 0", en_seen);
    end
    btn_inc = 1'b0;
    step();
    btn_inc = 1'b1;
    step();
    tests++;
    if (en !== 1'b1) begin
      fails++;
      $display("FAIL simul_repress: got en=%b want 1", en);
    end
    btn_inc = 1'b0;
    step();
  endtask

  task automatic test_blink();
    int k;
    enter_state(1);
    k = 0;
    for (int c = 0; c < 3; c++) begin
      repeat ($urandom_range(1, 300)) begin
        ms_tick();
        k++;
      end
      tests++;
      if (blink_hi !== 1'((k / BlinkMs) % 2) || blink_lo !== 1'b0) begin
        fails++;
        $display("FAIL blink_hour_k%0d: got bh=%b bl=%b want bh=%0d bl=0", k, blink_hi,
                 blink_lo, (k / BlinkMs) % 2);
      end
    end
    while (((k / BlinkMs) % 2) == 0) begin
      ms_tick();
      k++;
    end
    btn_inc = 1'b1;
    step();
    tests++;
    if (blink_hi !== 1'b0) begin
      fails++;
      $display("FAIL blink_inc_held: got bh=%b want 0", blink_hi);
    end
    btn_inc = 1'b0;
    step();
    tests++;
    if (blink_hi !== 1'b1) begin
      fails++;
      $display("FAIL blink_inc_released: got bh=%b want 1", blink_hi);
    end
    press_mode();
    tests++;
    if (blink_hi !== 1'b0 || blink_lo !== 1'b0) begin
      fails++;
      $display("FAIL blink_entry_min: got bh=%b bl=%b want 0 0", blink_hi, blink_lo);
    end
    repeat (BlinkMs + 10) ms_tick();
    tests++;
    if (blink_hi !== 1'b0 || blink_lo !== 1'b1) begin
      fails++;
      $display("FAIL blink_min_phase: got bh=%b bl=%b want 0 1", blink_hi, blink_lo);
    end
  endtask

  task automatic test_reset_mid_repeat();
    enter_state(1);
    btn_inc = 1'b1;
    step();
    for (int n = 0; n < 600; n++) ms_tick();
    tests++;
    if (en_seen != 2) begin
      fails++;
      $display("FAIL midrep_before: got %0d pulses want 2", en_seen);
    end
    cr = 1'b1;
    step();
    tests++;
    if (en !== 1'b0 || mode !== 2'b00 || run_en !== 1'b1) begin
      fails++;
      $display("FAIL midrep_cr: got en=%b mode=%b run_en=%b want 0 00 1", en, mode, run_en);
    end
    cr = 1'b0;
    clear_log();
    for (int n = 0; n < 800; n++) ms_tick();
    tests++;
    if (en_seen != 0 || mode !== 2'b00) begin
      fails++;
      $display("FAIL midrep_after: got %0d pulses mode=%b want 0 pulses mode=00", en_seen, mode);
    end
    btn_inc = 1'b0;
    step();
  endtask

  initial begin
    cr = 1'b1; tick_ms = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    clear_log();
    test_reset();
    test_modes();
    test_short_press();
    test_hold(1100);
    test_hold(int'($urandom_range(0, 1300)));
    test_timeout();
    test_simultaneous();
    test_blink();
    test_reset_mid_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
